// File: rtl/cynapse_div_pkg.sv
// Shared definitions for the iterative divider: controller states and default widths.
package cynapse_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam int DEF_DVND_W = 32;
  localparam int DEF_DVSR_W = 32;
  localparam int DEF_FRAC   = 0;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module div_step
  import cynapse_div_pkg::*;
#(
  parameter int DVSR_W = DEF_DVSR_W
) (
  input  logic [DVSR_W:0]   part_rem,
  input  logic              next_bit,
  input  logic [DVSR_W-1:0] dvsr,
  output logic [DVSR_W:0]   new_rem,
  output logic              q_bit
);

  logic [DVSR_W:0] shifted_s;
  logic [DVSR_W:0] diff_s;

  // Partial remainder is always below the divisor, so the shifted value fits in DVSR_W+1 bits.
  always_comb begin
    shifted_s = (part_rem << 1) | {{DVSR_W{1'b0}}, next_bit};
    diff_s    = shifted_s - {1'b0, dvsr};
    if (shifted_s >= {1'b0, dvsr}) begin
      new_rem = diff_s;
      q_bit   = 1'b1;
    end else begin
      new_rem = shifted_s;
      q_bit   = 1'b0;
    end
  end

endmodule

// File: rtl/iterative_divider.sv
// Unsigned restoring divider producing one quotient bit per cycle, with a
// valid/ready handshake on both operands and result.
module iterative_divider
  import cynapse_div_pkg::*;
#(
  parameter int DVND_W = DEF_DVND_W,
  parameter int DVSR_W = DEF_DVSR_W,
  parameter int FRAC   = DEF_FRAC,
  localparam int QW    = DVND_W + FRAC,
  localparam int CW    = $clog2(QW + 1)
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DVND_W-1:0] dividend,
  input  logic [DVSR_W-1:0] divisor,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [QW-1:0]     quotient,
  output logic [DVSR_W-1:0] remainder,
  output logic              div_by_zero
);

  div_state_e        state_r, state_n_s;
  logic [CW-1:0]     cnt_r;
  logic [QW-1:0]     qd_r;
  logic [DVSR_W:0]   rem_r;
  logic [DVSR_W-1:0] dvsr_r;
  logic              dz_r;
  logic              in_ready_r;
  logic              out_valid_r;
  logic              accept_s;
  logic              out_hs_s;
  logic              last_s;
  logic [DVSR_W:0]   step_rem_s;
  logic              step_q_s;

  assign accept_s = in_valid && in_ready_r;
  assign out_hs_s = out_valid_r && out_ready;
  assign last_s   = (cnt_r == CW'(QW - 1));

  // qd_r holds the unconsumed dividend bits in its top and collects quotient bits at the bottom.
  div_step #(.DVSR_W(DVSR_W)) u_step (
    .part_rem (rem_r),
    .next_bit (qd_r[QW-1]),
    .dvsr     (dvsr_r),
    .new_rem  (step_rem_s),
    .q_bit    (step_q_s)
  );

  // Next-state decode for the job controller.
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_n_s = (divisor == {DVSR_W{1'b0}}) ? DONE : BUSY;
        end else begin
          state_n_s = IDLE;
        end
      end
      BUSY: begin
        if (last_s) begin
          state_n_s = DONE;
        end else begin
          state_n_s = BUSY;
        end
      end
      DONE: begin
        if (out_hs_s) begin
          state_n_s = IDLE;
        end else begin
          state_n_s = DONE;
        end
      end
      default: state_n_s = IDLE;
    endcase
  end

  // State register and handshake flags; out_valid trails entry into DONE by one cycle.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_n_s;
      in_ready_r  <= (state_n_s == IDLE);
      out_valid_r <= (state_r == DONE) && (state_n_s == DONE);
    end
  end

  // Operand capture and the per-cycle shift-subtract datapath.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt_r  <= '0;
      qd_r   <= '0;
      rem_r  <= '0;
      dvsr_r <= '0;
      dz_r   <= 1'b0;
    end else if (accept_s) begin
      cnt_r  <= '0;
      dvsr_r <= divisor;
      if (divisor == {DVSR_W{1'b0}}) begin
        qd_r  <= '1;
        rem_r <= {1'b0, DVSR_W'(dividend)};
        dz_r  <= 1'b1;
      end else begin
        qd_r  <= QW'(dividend) << FRAC;
        rem_r <= '0;
        dz_r  <= 1'b0;
      end
    end else if (state_r == BUSY) begin
      cnt_r <= cnt_r + CW'(1);
      qd_r  <= (qd_r << 1) | {{(QW-1){1'b0}}, step_q_s};
      rem_r <= step_rem_s;
    end else begin
      cnt_r <= cnt_r;
      qd_r  <= qd_r;
      rem_r <= rem_r;
    end
  end

  assign in_ready    = in_ready_r;
  assign out_valid   = out_valid_r;
  assign quotient    = qd_r;
  assign remainder   = rem_r[DVSR_W-1:0];
  assign div_by_zero = dz_r;

endmodule

// File: tb/tb_iterative_divider.sv
// Directed and randomised checks of iterative_divider at FRAC=0 and FRAC=8,
// using a queue of model results compared when each result appears.
module tb_iterative_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        iv0, iv1;
  logic        ir0, ir1;
  logic        ov0, ov1;
  logic        dz0, dz1;
  logic        ordy;
  logic [31:0] a, b;
  logic [31:0] q0, r0, r1;
  logic [39:0] q1;

  typedef struct {
    logic [63:0] q;
    logic [31:0] r;
    logic        dz;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  iterative_divider dut0 (
    .Clock(clk), .Reset(rst), .in_valid(iv0), .in_ready(ir0),
    .dividend(a), .divisor(b), .out_valid(ov0), .out_ready(ordy),
    .quotient(q0), .remainder(r0), .div_by_zero(dz0)
  );

  iterative_divider #(.FRAC(8)) dut1 (
    .Clock(clk), .Reset(rst), .in_valid(iv1), .in_ready(ir1),
    .dividend(a), .divisor(b), .out_valid(ov1), .out_ready(ordy),
    .quotient(q1), .remainder(r1), .div_by_zero(dz1)
  );

  function automatic logic get_ov(input int sel);
    return (sel != 0) ? ov1 : ov0;
  endfunction
  function automatic logic get_ir(input int sel);
    return (sel != 0) ? ir1 : ir0;
  endfunction
  function automatic logic [63:0] get_q(input int sel);
    return (sel != 0) ? 64'(q1) : 64'(q0);
  endfunction
  function automatic logic [31:0] get_r(input int sel);
    return (sel != 0) ? r1 : r0;
  endfunction
  function automatic logic get_dz(input int sel);
    return (sel != 0) ? dz1 : dz0;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int sel, input logic [31:0] x, input logic [31:0] y);
    exp_t        e;
    logic [63:0] num;
    int          frac;
    frac = (sel != 0) ? 8 : 0;
    if (y == 32'd0) begin
      e.q  = (sel != 0) ? 64'h0000_00FF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
      e.r  = x;
      e.dz = 1'b1;
    end else begin
      num  = {32'd0, x} << frac;
      e.q  = num / {32'd0, y};
      e.r  = 32'(num % {32'd0, y});
      e.dz = 1'b0;
    end
    return e;
  endfunction

  // Present operands on a falling edge; acceptance is the following rising edge.
  task automatic start_job(input int sel, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    check("in_ready_idle", 64'(get_ir(sel)), 64'd1);
    a = x;
    b = y;
    if (sel != 0) iv1 = 1'b1;
    else          iv0 = 1'b1;
    sbq.push_back(model(sel, x, y));
    @(posedge clk);
    #1;
    iv0 = 1'b0;
    iv1 = 1'b0;
    a   = $urandom;
    b   = $urandom;
  endtask

  // Count edges from acceptance until out_valid, then compare against the queued result.
  task automatic wait_out(input int sel, input string tag, input int exp_lat);
    int   n;
    exp_t e;
    n = 0;
    while (get_ov(sel) !== 1'b1 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_lat"}, 64'(n), 64'(exp_lat));
    check({tag, "_in_ready_low"}, 64'(get_ir(sel)), 64'd0);
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      check({tag, "_q"}, get_q(sel), e.q);
      check({tag, "_r"}, 64'(get_r(sel)), 64'(e.r));
      check({tag, "_dz"}, 64'(get_dz(sel)), 64'(e.dz));
    end else begin
      check({tag, "_scoreboard_empty"}, 64'd1, 64'(sbq.size()));
    end
  endtask

  // With out_ready high the handshake takes the next edge; in_ready must return right after.
  task automatic finish_job(input int sel, input string tag);
    ordy = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_ov_drop"}, 64'(get_ov(sel)), 64'd0);
    check({tag, "_in_ready_back"}, 64'(get_ir(sel)), 64'd1);
  endtask

  initial begin
    logic [31:0] x, y;
    logic        seen;
    string       tag;
    rst  = 1'b1;
    iv0  = 1'b0;
    iv1  = 1'b0;
    ordy = 1'b1;
    a    = 32'd0;
    b    = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(ir0), 64'd1);
    check("rst_out_valid", 64'(ov0), 64'd0);
    check("rst_q", 64'(q0), 64'd0);
    check("rst_r", 64'(r0), 64'd0);
    check("rst_dz", 64'(dz0), 64'd0);
    check("rst_q_frac", 64'(q1), 64'd0);
    rst = 1'b0;

    start_job(0, 32'd100, 32'd7);
    wait_out(0, "d100_7", 33);
    finish_job(0, "d100_7");

    start_job(1, 32'd1, 32'd3);
    wait_out(1, "f1_3", 41);
    finish_job(1, "f1_3");

    start_job(0, 32'd1234, 32'd0);
    wait_out(0, "dz1234", 1);
    finish_job(0, "dz1234");

    ordy = 1'b0;
    start_job(0, 32'hFFFF_FFFF, 32'd1);
    wait_out(0, "bp", 33);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("bp_hold_ov", 64'(ov0), 64'd1);
      check("bp_hold_q", 64'(q0), 64'h0000_0000_FFFF_FFFF);
      check("bp_hold_r", 64'(r0), 64'd0);
      check("bp_in_ready", 64'(ir0), 64'd0);
    end
    finish_job(0, "bp");

    start_job(0, 32'd50, 32'd5);
    void'(sbq.pop_back());
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_in_ready", 64'(ir0), 64'd1);
    check("abort_q", 64'(q0), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (ov0 === 1'b1) seen = 1'b1;
    end
    check("abort_no_valid", 64'(seen), 64'd0);
    start_job(0, 32'd9, 32'd4);
    wait_out(0, "post_abort", 33);
    finish_job(0, "post_abort");

    start_job(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_out(0, "ones_ones", 33);
    finish_job(0, "ones_ones");

    start_job(0, 32'd5, 32'd7);
    wait_out(0, "small", 33);
    finish_job(0, "small");

    start_job(1, 32'hFFFF_FFFF, 32'd1);
    wait_out(1, "f_div1", 41);
    finish_job(1, "f_div1");

    start_job(1, 32'd77, 32'd0);
    wait_out(1, "f_dz", 1);
    finish_job(1, "f_dz");

    start_job(1, 32'd5, 32'd9000);
    wait_out(1, "f_small", 41);
    finish_job(1, "f_small");

    for (int i = 0; i < 12; i++) begin
      int sel;
      sel = (i % 4 == 3) ? 1 : 0;
      x   = $urandom;
      y   = $urandom;
      if (i % 3 == 0) y = 32'($urandom_range(1, 255));
      if (i == 5)     y = 32'd0;
      tag = $sformatf("rnd%0d", i);
      start_job(sel, x, y);
      wait_out(sel, tag, (y == 32'd0) ? 1 : ((sel != 0) ? 41 : 33));
      finish_job(sel, tag);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
